// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the timer/device interrupt controller.
// Register offsets decoded from Addr_In[3:2]:
//   PEND, MASK, STAT, EOI. FSM state encodings are IDLE, REQ and SVC.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of vec_i.
// Latency: combinational. Backpressure: none.
// Ports: vec_i request vector; idx_o winning index; vld_o any bit set.
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] vec_i,
  output logic [2:0]   idx_o,
  output logic         vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = |vec_i;
    // Walk from the top down so the lowest set index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/timer_irq_controller.sv
// Interrupt controller: latches/masks sources, raises one request to CP0 by fixed priority.
// Latency: level source -> IRQ_Out one edge later; edge source -> two edges (via PEND flop).
// Backpressure: one outstanding request; blocks new requests from ack until a matching EOI write.
// Ports: clk/reset; bridge register port Addr_In/WE/Data_In/Data_Out; Src_IRQ raw lines;
//        Int_Ack from CP0; IRQ_Out/Vec_Out request and source index to CP0.
module timer_irq_controller #(
  parameter int                 NUM_SRC   = 6,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:2]         Addr_In,
  input  logic               WE,
  input  logic [31:0]        Data_In,
  output logic [31:0]        Data_Out,
  input  logic [NUM_SRC-1:0] Src_IRQ,
  input  logic               Int_Ack,
  output logic               IRQ_Out,
  output logic [2:0]         Vec_Out
);
  import irq_ctrl_pkg::*;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] prev_q;
  logic               irq_q, irq_d;
  logic [2:0]         vec_q, vec_d;

  logic [NUM_SRC-1:0] pend_view, elig, rise, w1c, ack_clr;
  logic [2:0]         win;
  logic               win_vld;
  logic               wr_pend, wr_mask, wr_eoi, ack_take;
  logic               unused_data;

  assign unused_data = ^Data_In[31:NUM_SRC];

  assign wr_pend = WE && (Addr_In == ADDR_PEND);
  assign wr_mask = WE && (Addr_In == ADDR_MASK);
  assign wr_eoi  = WE && (Addr_In == ADDR_EOI);
  assign ack_take = (state_q == ST_REQ) && Int_Ack;

  // Level bits bypass the PEND flop entirely; only edge bits are latched.
  assign pend_view = (pend_q & EDGE_MASK) | (Src_IRQ & ~EDGE_MASK);
  assign elig      = pend_view & mask_q;
  assign rise      = Src_IRQ & ~prev_q;
  assign w1c       = wr_pend ? Data_In[NUM_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_take && (vec_q == 3'(i));
    end
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  assign pend_d = EDGE_MASK & (rise | (pend_q & ~(w1c | ack_clr)));
  assign mask_d = wr_mask ? Data_In[NUM_SRC-1:0] : mask_q;

  irq_prio_enc #(.N(NUM_SRC)) u_prio (
    .vec_i (elig),
    .idx_o (win),
    .vld_o (win_vld)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          vec_d   = win;
        end
      end
      ST_REQ: begin
        if (Int_Ack) begin
          state_d = ST_SVC;
          irq_d   = 1'b0;
        end else if (!win_vld) begin
          // Request withdrawn; Vec_Out keeps the last index.
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end else begin
          vec_d = win;
        end
      end
      ST_SVC: begin
        irq_d = 1'b0;
        if (wr_eoi && (Data_In[2:0] == vec_q)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      prev_q  <= Src_IRQ;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    Data_Out = '0;
    case (Addr_In)
      ADDR_PEND: Data_Out = 32'(pend_view);
      ADDR_MASK: Data_Out = 32'(mask_q);
      ADDR_STAT: Data_Out = {22'b0, state_q, 5'b0, vec_q};
      ADDR_EOI:  Data_Out = 32'(Src_IRQ);
      default:   Data_Out = '0;
    endcase
  end

  assign IRQ_Out = irq_q;
  assign Vec_Out = vec_q;

endmodule
